// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: in-flight scoreboard of post-decode destinations that
// decides fetch/decode stall, E-stage bubble and branch flush, plus a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned RW     = 5,
    parameter int unsigned FWD_EN = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [RW-1:0]          id_rs1,
    input  logic                   id_rs1_used,
    input  logic [RW-1:0]          id_rs2,
    input  logic                   id_rs2_used,
    input  logic [RW-1:0]          id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   ex_busy,
    input  logic                   redirect,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   bubble_e,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic [NSTAGE-1:0]      stg_valid,
    output logic [NSTAGE*RW-1:0]   stg_rd,
    output logic [NSTAGE-1:0]      stg_we,
    output logic [CNT_W-1:0]       stall_cnt
);

    // How entry 0 / entry 1 are updated on the next edge.
    typedef enum logic [1:0] {
        SB_ISSUE  = 2'd0,
        SB_HOLD   = 2'd1,
        SB_FLUSH  = 2'd2,
        SB_BUBBLE = 2'd3
    } sb_op_e;

    logic [NSTAGE-1:0]         valid_q;
    logic [NSTAGE-1:0]         we_q;
    logic [NSTAGE-1:0][RW-1:0] rd_q;
    logic                      ld_e_q;     // load flag only matters while the producer sits in E
    logic [CNT_W-1:0]          stall_cnt_q;

    logic [NSTAGE-1:0]         hit_c;
    logic                      hazard_c;
    sb_op_e                    sb_op_c;

    // Per-stage RAW match against either decode source.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < int'(NSTAGE); i++) begin
            hit_c[i] = valid_q[i] & we_q[i] &
                       ((id_rs1_used & (id_rs1 != '0) & (rd_q[i] == id_rs1)) |
                        (id_rs2_used & (id_rs2 != '0) & (rd_q[i] == id_rs2)));
        end
    end

    // W is excluded: the register file writes before it is read.
    always_comb begin
        hazard_c = 1'b0;
        if (FWD_EN != 0) begin
            hazard_c = hit_c[0] & ld_e_q;
        end else begin
            for (int i = 0; i < int'(NSTAGE) - 1; i++) begin
                hazard_c = hazard_c | hit_c[i];
            end
        end
    end

    // Priority resolution: multi-cycle hold, then redirect, then data hazard.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        bubble_e = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        sb_op_c  = SB_ISSUE;
        if (rst) begin
            if (ex_busy) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                sb_op_c = SB_HOLD;
            end else if (redirect) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                sb_op_c = SB_FLUSH;
            end else if (id_valid && hazard_c) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                bubble_e = 1'b1;
                sb_op_c  = SB_BUBBLE;
            end
        end
    end

    // Scoreboard shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            we_q    <= '0;
            rd_q    <= '0;
            ld_e_q  <= 1'b0;
        end else begin
            for (int i = 1; i < int'(NSTAGE); i++) begin
                valid_q[i] <= valid_q[i-1];
                we_q[i]    <= we_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
            case (sb_op_c)
                SB_HOLD: begin
                    valid_q[1] <= 1'b0;
                    we_q[1]    <= 1'b0;
                    rd_q[1]    <= '0;
                end
                SB_ISSUE: begin
                    valid_q[0] <= id_valid;
                    we_q[0]    <= id_reg_write & id_valid;
                    rd_q[0]    <= id_rd;
                    ld_e_q     <= id_mem_read & id_valid;
                end
                default: begin
                    valid_q[0] <= 1'b0;
                    we_q[0]    <= 1'b0;
                    rd_q[0]    <= '0;
                    ld_e_q     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stg_valid = valid_q;
    assign stg_we    = we_q;
    assign stg_rd    = rd_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: no-forwarding, forwarding and narrow-counter
// instances share one stimulus; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic       ex_busy, redirect;

    logic        nf_stall_f, nf_stall_d, nf_bubble_e, nf_flush_d, nf_flush_e;
    logic [2:0]  nf_stg_valid, nf_stg_we;
    logic [14:0] nf_stg_rd;
    logic [15:0] nf_stall_cnt;

    logic        fw_stall_f, fw_stall_d, fw_bubble_e, fw_flush_d, fw_flush_e;
    logic [2:0]  fw_stg_valid, fw_stg_we;
    logic [14:0] fw_stg_rd;
    logic [15:0] fw_stall_cnt;

    logic        st_stall_f, st_stall_d, st_bubble_e, st_flush_d, st_flush_e;
    logic [3:0]  st_stg_valid, st_stg_we;
    logic [19:0] st_stg_rd;
    logic [3:0]  st_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGE(3), .RW(5), .FWD_EN(0), .CNT_W(16)) u_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_busy(ex_busy), .redirect(redirect),
        .stall_f(nf_stall_f), .stall_d(nf_stall_d), .bubble_e(nf_bubble_e), .flush_d(nf_flush_d),
        .flush_e(nf_flush_e), .stg_valid(nf_stg_valid), .stg_rd(nf_stg_rd), .stg_we(nf_stg_we),
        .stall_cnt(nf_stall_cnt));

    pipe_hazard_ctrl #(.NSTAGE(3), .RW(5), .FWD_EN(1), .CNT_W(16)) u_fw (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_busy(ex_busy), .redirect(redirect),
        .stall_f(fw_stall_f), .stall_d(fw_stall_d), .bubble_e(fw_bubble_e), .flush_d(fw_flush_d),
        .flush_e(fw_flush_e), .stg_valid(fw_stg_valid), .stg_rd(fw_stg_rd), .stg_we(fw_stg_we),
        .stall_cnt(fw_stall_cnt));

    pipe_hazard_ctrl #(.NSTAGE(4), .RW(5), .FWD_EN(0), .CNT_W(4)) u_st (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .ex_busy(ex_busy), .redirect(redirect),
        .stall_f(st_stall_f), .stall_d(st_stall_d), .bubble_e(st_bubble_e), .flush_d(st_flush_d),
        .flush_e(st_flush_e), .stg_valid(st_stg_valid), .stg_rd(st_stg_rd), .stg_we(st_stg_we),
        .stall_cnt(st_stall_cnt));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                            input logic we, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = we; id_mem_read = mr;
    endtask

    task automatic apply_reset();
        rst = 1'b0; ex_busy = 1'b0; redirect = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ex_busy = 1'b1; redirect = 1'b1;
        drive_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL rst_stall_d: got %b exp 0", nf_stall_d); end
        vectors++; if (nf_flush_d !== 1'b0) begin miscompares++; $display("FAIL rst_flush_d: got %b exp 0", nf_flush_d); end
        vectors++; if (nf_stg_valid !== 3'b000) begin miscompares++; $display("FAIL rst_stg_valid: got %b exp 000", nf_stg_valid); end
        tick();
        vectors++; if (nf_stall_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_cnt_held: got %0d exp 0", nf_stall_cnt); end
        redirect = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        vectors++; if (nf_stall_d !== 1'b1) begin miscompares++; $display("FAIL rel_stall_d: got %b exp 1", nf_stall_d); end
        tick();
        vectors++; if (nf_stall_cnt !== 16'd1) begin miscompares++; $display("FAIL rel_cnt: got %0d exp 1", nf_stall_cnt); end
        ex_busy = 1'b0;
    endtask

    task automatic test_raw_nofwd();
        apply_reset();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x0,imm
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL raw_prod_stall: got %b exp 0", nf_stall_d); end
        tick();
        vectors++; if (nf_stg_valid !== 3'b001) begin miscompares++; $display("FAIL raw_v0: got %b exp 001", nf_stg_valid); end
        drive_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
        #1;
        vectors++; if ({nf_stall_f, nf_stall_d, nf_bubble_e} !== 3'b111) begin miscompares++; $display("FAIL raw_c1_stall: got %b exp 111", {nf_stall_f, nf_stall_d, nf_bubble_e}); end
        tick();
        vectors++; if (nf_stg_valid !== 3'b010) begin miscompares++; $display("FAIL raw_v1: got %b exp 010", nf_stg_valid); end
        vectors++; if (nf_stall_d !== 1'b1) begin miscompares++; $display("FAIL raw_c2_stall: got %b exp 1", nf_stall_d); end
        tick();
        vectors++; if (nf_stg_valid !== 3'b100) begin miscompares++; $display("FAIL raw_v2: got %b exp 100", nf_stg_valid); end
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL raw_w_excl: got %b exp 0", nf_stall_d); end
        vectors++; if (nf_stall_cnt !== 16'd2) begin miscompares++; $display("FAIL raw_cnt: got %0d exp 2", nf_stall_cnt); end
        tick();
        vectors++; if (nf_stg_valid !== 3'b001) begin miscompares++; $display("FAIL raw_cons_e: got %b exp 001", nf_stg_valid); end
        vectors++; if (nf_stg_rd[4:0] !== 5'd6) begin miscompares++; $display("FAIL raw_cons_rd: got %0d exp 6", nf_stg_rd[4:0]); end
    endtask

    task automatic test_load_use_fwd();
        apply_reset();
        drive_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7,0(x2)
        tick();
        drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
        #1;
        vectors++; if ({fw_stall_d, fw_bubble_e} !== 2'b11) begin miscompares++; $display("FAIL lu_stall: got %b exp 11", {fw_stall_d, fw_bubble_e}); end
        tick();
        vectors++; if (fw_stall_d !== 1'b0) begin miscompares++; $display("FAIL lu_one_bubble: got %b exp 0", fw_stall_d); end
        vectors++; if (fw_stg_valid !== 3'b010) begin miscompares++; $display("FAIL lu_v: got %b exp 010", fw_stg_valid); end
        vectors++; if (fw_stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_cnt: got %0d exp 1", fw_stall_cnt); end
        tick();
        vectors++; if ({fw_stg_valid, fw_stg_rd[4:0]} !== {3'b101, 5'd8}) begin miscompares++; $display("FAIL lu_issue: got %b/%0d exp 101/8", fw_stg_valid, fw_stg_rd[4:0]); end

        apply_reset();
        drive_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // addi x7,x2,imm
        tick();
        drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        vectors++; if (fw_stall_d !== 1'b0) begin miscompares++; $display("FAIL alu_fwd_nostall: got %b exp 0", fw_stall_d); end
        tick();
        vectors++; if (fw_stall_cnt !== 16'd0) begin miscompares++; $display("FAIL alu_fwd_cnt: got %0d exp 0", fw_stall_cnt); end
    endtask

    task automatic test_x0();
        apply_reset();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // write to x0 flagged as load too
        tick();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x0,x0
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL x0_nf: got %b exp 0", nf_stall_d); end
        vectors++; if (fw_stall_d !== 1'b0) begin miscompares++; $display("FAIL x0_fw: got %b exp 0", fw_stall_d); end
    endtask

    task automatic test_redirect();
        apply_reset();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        redirect = 1'b1;
        #1;
        vectors++; if ({nf_flush_d, nf_flush_e, nf_stall_d, nf_bubble_e} !== 4'b1100) begin miscompares++; $display("FAIL redir_hz: got %b exp 1100", {nf_flush_d, nf_flush_e, nf_stall_d, nf_bubble_e}); end
        tick();
        vectors++; if (nf_stg_valid !== 3'b010) begin miscompares++; $display("FAIL redir_e0: got %b exp 010", nf_stg_valid); end
        ex_busy = 1'b1;
        #1;
        vectors++; if ({nf_flush_d, nf_flush_e, nf_stall_d} !== 3'b001) begin miscompares++; $display("FAIL redir_busy: got %b exp 001", {nf_flush_d, nf_flush_e, nf_stall_d}); end
        tick();
        ex_busy = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_ex_busy();
        apply_reset();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        ex_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++; if (nf_stall_d !== 1'b1) begin miscompares++; $display("FAIL busy_stall[%0d]: got %b exp 1", c, nf_stall_d); end
            tick();
            vectors++; if (nf_stg_valid[1:0] !== 2'b01) begin miscompares++; $display("FAIL busy_stg[%0d]: got %b exp 01", c, nf_stg_valid[1:0]); end
        end
        ex_busy = 1'b0;
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL busy_release: got %b exp 0", nf_stall_d); end
        tick();
        vectors++; if ({nf_stg_valid[1:0], nf_stg_rd[9:0]} !== {2'b11, 5'd5, 5'd10}) begin miscompares++; $display("FAIL busy_adv: got %b/%h exp 11/%h", nf_stg_valid[1:0], nf_stg_rd[9:0], {5'd5, 5'd10}); end
        vectors++; if (nf_stall_cnt !== 16'd4) begin miscompares++; $display("FAIL busy_cnt: got %0d exp 4", nf_stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stall: got %b exp 0", nf_stall_d); end
        tick();
        rst = 1'b1;
        #1;
        vectors++; if (nf_stall_d !== 1'b0) begin miscompares++; $display("FAIL mid_rst_resid: got %b exp 0", nf_stall_d); end
    endtask

    task automatic test_saturate();
        apply_reset();
        ex_busy = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) begin
                vectors++; if (st_stall_cnt !== 4'd14) begin miscompares++; $display("FAIL sat_pre: got %0d exp 14", st_stall_cnt); end
            end
        end
        vectors++; if (st_stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_hold: got %0d exp 15", st_stall_cnt); end
        ex_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ex_busy = 1'b0; redirect = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_raw_nofwd();
        test_load_use_fwd();
        test_x0();
        test_redirect();
        test_ex_busy();
        test_reset_mid_stall();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
